// File: rtl/data_mem_arbiter_if.sv
// Requester-side bus of the data memory arbiter: request/command signals
// from a requester plus the grant/done/err/rdata response from the arbiter.
interface data_mem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              done;
  logic              err;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, done, err, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, done, err, rdata
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the single-port
// 32x8 data memory. Requester 0 is the CPU load/store path, requester 1 the
// debug/loader port. One access completes every two cycles: an ACCESS cycle
// that drives the memory pins, followed by a done cycle that returns data.
module data_mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32
) (
  input  logic               clk,
  input  logic               reset,
  data_mem_arbiter_if.slave  r0,
  data_mem_arbiter_if.slave  r1,
  output logic               mem_read,
  output logic               mem_write,
  output logic [ADDR_W-1:0]  mem_address,
  output logic [DATA_W-1:0]  mem_write_data,
  input  logic [DATA_W-1:0]  mem_read_data
);

  typedef enum logic {IDLE, ACCESS} state_t;

  // One extra bit so the range check is on the full unsigned address.
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH);

  state_t            state, next_state;
  logic              last_grant;
  logic              winner;
  logic              any_req;
  logic              lat_we;
  logic              lat_id;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              in_range;
  logic              gnt0, gnt1;
  logic              done0, done1;
  logic              err0, err1;
  logic [DATA_W-1:0] rdata0, rdata1;

  assign in_range = ({1'b0, lat_addr} < DEPTH_EXT);

  // Winner selection, next state, and the ACCESS-cycle grant/memory strobes.
  always_comb begin
    next_state = state;
    any_req    = r0.req | r1.req;
    winner     = 1'b0;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    if (r0.req && r1.req) begin
      winner = ~last_grant;
    end else begin
      winner = r1.req;
    end
    case (state)
      IDLE: begin
        if (any_req) begin
          next_state = ACCESS;
        end
      end
      ACCESS: begin
        next_state = IDLE;
        gnt0       = ~lat_id;
        gnt1       = lat_id;
        mem_write  = in_range & lat_we;
        mem_read   = in_range & ~lat_we;
      end
      default: next_state = IDLE;
    endcase
  end

  // State register; reset aborts any access in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Latch the winning command on arbitration and produce the done/err/rdata response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
      lat_we     <= 1'b0;
      lat_id     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      err0       <= 1'b0;
      err1       <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      err0  <= 1'b0;
      err1  <= 1'b0;
      if (state == IDLE && any_req) begin
        last_grant <= winner;
        lat_id     <= winner;
        lat_we     <= winner ? r1.we    : r0.we;
        lat_addr   <= winner ? r1.addr  : r0.addr;
        lat_wdata  <= winner ? r1.wdata : r0.wdata;
      end
      if (state == ACCESS) begin
        if (lat_id) begin
          done1  <= 1'b1;
          err1   <= ~in_range;
          rdata1 <= (in_range && !lat_we) ? mem_read_data : '0;
        end else begin
          done0  <= 1'b1;
          err0   <= ~in_range;
          rdata0 <= (in_range && !lat_we) ? mem_read_data : '0;
        end
      end
    end
  end

  assign r0.gnt         = gnt0;
  assign r1.gnt         = gnt1;
  assign r0.done        = done0;
  assign r1.done        = done1;
  assign r0.err         = err0;
  assign r1.err         = err1;
  assign r0.rdata       = rdata0;
  assign r1.rdata       = rdata1;
  assign mem_address    = lat_addr;
  assign mem_write_data = lat_wdata;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed testbench for data_mem_arbiter with a behavioural 32x8 memory
// (preloaded mem[i] = i) attached to the memory pins.
module tb_data_mem_arbiter;

  logic       clk;
  logic       reset;
  logic       mem_read;
  logic       mem_write;
  logic [7:0] mem_address;
  logic [7:0] mem_write_data;
  logic [7:0] mem_read_data;
  logic [7:0] mem [0:255];
  int         total;
  int         bad;

  data_mem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) r0_if ();
  data_mem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) r1_if ();

  data_mem_arbiter #(.ADDR_W(8), .DATA_W(8), .DEPTH(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .r0             (r0_if),
    .r1             (r1_if),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: combinational read, write on rising edge.
  assign mem_read_data = mem[mem_address];

  always @(posedge clk) begin
    if (mem_write) mem[mem_address] <= mem_write_data;
  end

  task automatic idle_all();
    r0_if.req = 1'b0; r0_if.we = 1'b0; r0_if.addr = 8'h00; r0_if.wdata = 8'h00;
    r1_if.req = 1'b0; r1_if.we = 1'b0; r1_if.addr = 8'h00; r1_if.wdata = 8'h00;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (r0_if.gnt !== 1'b0 || r1_if.gnt !== 1'b0) begin bad++; $display("[TB] FAIL rst_gnt: got %b%b want 00", r0_if.gnt, r1_if.gnt); end
    total++; if (r0_if.done !== 1'b0 || r1_if.done !== 1'b0 || r0_if.err !== 1'b0 || r1_if.err !== 1'b0) begin bad++; $display("[TB] FAIL rst_done_err: got done %b%b err %b%b want 0", r0_if.done, r1_if.done, r0_if.err, r1_if.err); end
    total++; if (r0_if.rdata !== 8'h00 || r1_if.rdata !== 8'h00) begin bad++; $display("[TB] FAIL rst_rdata: got %h %h want 00 00", r0_if.rdata, r1_if.rdata); end
    total++; if (mem_read !== 1'b0 || mem_write !== 1'b0 || mem_address !== 8'h00 || mem_write_data !== 8'h00) begin bad++; $display("[TB] FAIL rst_mem: got rd %b wr %b a %h d %h want 0", mem_read, mem_write, mem_address, mem_write_data); end
    reset = 1'b0;
  endtask

  task automatic test_read();
    r0_if.req = 1'b1; r0_if.we = 1'b0; r0_if.addr = 8'd5;
    @(posedge clk); #1;
    total++; if (r0_if.gnt !== 1'b1 || r1_if.gnt !== 1'b0) begin bad++; $display("[TB] FAIL rd_gnt: got %b%b want r0=1 r1=0", r0_if.gnt, r1_if.gnt); end
    total++; if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_address !== 8'd5) begin bad++; $display("[TB] FAIL rd_mem: got rd %b wr %b a %h want 1 0 05", mem_read, mem_write, mem_address); end
    r0_if.req = 1'b0;
    @(posedge clk); #1;
    total++; if (r0_if.done !== 1'b1 || r0_if.err !== 1'b0 || r0_if.gnt !== 1'b0) begin bad++; $display("[TB] FAIL rd_done: got done %b err %b gnt %b want 1 0 0", r0_if.done, r0_if.err, r0_if.gnt); end
    total++; if (r0_if.rdata !== 8'h05) begin bad++; $display("[TB] FAIL rd_data: got %h want 05", r0_if.rdata); end
    total++; if (mem_read !== 1'b0) begin bad++; $display("[TB] FAIL rd_idle_strobe: got %b want 0", mem_read); end
    @(posedge clk); #1;
    total++; if (r0_if.done !== 1'b0 || r0_if.rdata !== 8'h05) begin bad++; $display("[TB] FAIL rd_hold: got done %b rdata %h want 0 05", r0_if.done, r0_if.rdata); end
  endtask

  task automatic test_write_then_read();
    r1_if.req = 1'b1; r1_if.we = 1'b1; r1_if.addr = 8'd3; r1_if.wdata = 8'hA5;
    @(posedge clk); #1;
    total++; if (r1_if.gnt !== 1'b1 || r0_if.gnt !== 1'b0) begin bad++; $display("[TB] FAIL wr_gnt: got r1 %b r0 %b want 1 0", r1_if.gnt, r0_if.gnt); end
    total++; if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_address !== 8'd3 || mem_write_data !== 8'hA5) begin bad++; $display("[TB] FAIL wr_mem: got wr %b rd %b a %h d %h want 1 0 03 a5", mem_write, mem_read, mem_address, mem_write_data); end
    r1_if.req = 1'b0;
    @(posedge clk); #1;
    total++; if (r1_if.done !== 1'b1 || r1_if.err !== 1'b0 || r1_if.rdata !== 8'h00) begin bad++; $display("[TB] FAIL wr_done: got done %b err %b rdata %h want 1 0 00", r1_if.done, r1_if.err, r1_if.rdata); end
    total++; if (mem_write !== 1'b0 || mem_address !== 8'd3) begin bad++; $display("[TB] FAIL wr_idle: got wr %b a %h want 0 03", mem_write, mem_address); end
    r0_if.req = 1'b1; r0_if.we = 1'b0; r0_if.addr = 8'd3;
    @(posedge clk); #1;
    total++; if (r0_if.gnt !== 1'b1 || r1_if.done !== 1'b0) begin bad++; $display("[TB] FAIL rb_gnt: got gnt %b r1done %b want 1 0", r0_if.gnt, r1_if.done); end
    r0_if.req = 1'b0;
    @(posedge clk); #1;
    total++; if (r0_if.done !== 1'b1 || r0_if.rdata !== 8'hA5) begin bad++; $display("[TB] FAIL rb_data: got done %b rdata %h want 1 a5", r0_if.done, r0_if.rdata); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_data;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    r0_if.req = 1'b1; r0_if.we = 1'b0; r0_if.addr = 8'd10;
    r1_if.req = 1'b1; r1_if.we = 1'b0; r1_if.addr = 8'd20;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      total++;
      if ((k % 2) == 0) begin
        if (r0_if.gnt !== 1'b1 || r1_if.gnt !== 1'b0) begin bad++; $display("[TB] FAIL rr_gnt%0d: got r0 %b r1 %b want 1 0", k, r0_if.gnt, r1_if.gnt); end
      end else begin
        if (r0_if.gnt !== 1'b0 || r1_if.gnt !== 1'b1) begin bad++; $display("[TB] FAIL rr_gnt%0d: got r0 %b r1 %b want 0 1", k, r0_if.gnt, r1_if.gnt); end
      end
      @(posedge clk); #1;
      total++;
      if ((k % 2) == 0) begin
        exp_data = 8'h0A;
        if (r0_if.done !== 1'b1 || r1_if.done !== 1'b0 || r0_if.rdata !== exp_data) begin bad++; $display("[TB] FAIL rr_done%0d: got r0 %b r1 %b rdata %h want 1 0 %h", k, r0_if.done, r1_if.done, r0_if.rdata, exp_data); end
      end else begin
        exp_data = 8'h14;
        if (r0_if.done !== 1'b0 || r1_if.done !== 1'b1 || r1_if.rdata !== exp_data) begin bad++; $display("[TB] FAIL rr_done%0d: got r0 %b r1 %b rdata %h want 0 1 %h", k, r0_if.done, r1_if.done, r1_if.rdata, exp_data); end
      end
      total++; if (r0_if.gnt !== 1'b0 || r1_if.gnt !== 1'b0) begin bad++; $display("[TB] FAIL rr_gap%0d: got gnt %b%b in done cycle want 00", k, r0_if.gnt, r1_if.gnt); end
    end
    idle_all();
    @(posedge clk); #1;
  endtask

  task automatic test_out_of_range();
    r1_if.req = 1'b1; r1_if.we = 1'b1; r1_if.addr = 8'd32; r1_if.wdata = 8'hFF;
    @(posedge clk); #1;
    total++; if (r1_if.gnt !== 1'b1) begin bad++; $display("[TB] FAIL oor_gnt: got %b want 1", r1_if.gnt); end
    total++; if (mem_write !== 1'b0 || mem_read !== 1'b0) begin bad++; $display("[TB] FAIL oor_strobe: got wr %b rd %b want 0 0", mem_write, mem_read); end
    r1_if.req = 1'b0;
    @(posedge clk); #1;
    total++; if (r1_if.done !== 1'b1 || r1_if.err !== 1'b1 || r1_if.rdata !== 8'h00) begin bad++; $display("[TB] FAIL oor_done: got done %b err %b rdata %h want 1 1 00", r1_if.done, r1_if.err, r1_if.rdata); end
    r0_if.req = 1'b1; r0_if.we = 1'b0; r0_if.addr = 8'd31;
    @(posedge clk); #1;
    total++; if (r1_if.err !== 1'b0 || r0_if.gnt !== 1'b1) begin bad++; $display("[TB] FAIL oor_after: got err %b gnt %b want 0 1", r1_if.err, r0_if.gnt); end
    r0_if.req = 1'b0;
    @(posedge clk); #1;
    total++; if (r0_if.done !== 1'b1 || r0_if.err !== 1'b0 || r0_if.rdata !== 8'h1F) begin bad++; $display("[TB] FAIL oor_rd31: got done %b err %b rdata %h want 1 0 1f", r0_if.done, r0_if.err, r0_if.rdata); end
  endtask

  task automatic test_reset_mid_access();
    r0_if.req = 1'b1; r0_if.we = 1'b1; r0_if.addr = 8'd2; r0_if.wdata = 8'h77;
    @(posedge clk); #1;
    total++; if (r0_if.gnt !== 1'b1 || mem_write !== 1'b1) begin bad++; $display("[TB] FAIL mid_pre: got gnt %b wr %b want 1 1", r0_if.gnt, mem_write); end
    r0_if.req = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    total++; if (mem_write !== 1'b0 || mem_read !== 1'b0 || r0_if.gnt !== 1'b0) begin bad++; $display("[TB] FAIL mid_strobe: got wr %b rd %b gnt %b want 0", mem_write, mem_read, r0_if.gnt); end
    total++; if (mem_address !== 8'h00 || mem_write_data !== 8'h00 || r0_if.rdata !== 8'h00) begin bad++; $display("[TB] FAIL mid_regs: got a %h d %h rdata %h want 00", mem_address, mem_write_data, r0_if.rdata); end
    @(posedge clk); #1;
    reset = 1'b0;
    total++; if (r0_if.done !== 1'b0) begin bad++; $display("[TB] FAIL mid_nodone: got %b want 0", r0_if.done); end
    @(posedge clk); #1;
    total++; if (r0_if.done !== 1'b0 || r0_if.gnt !== 1'b0) begin bad++; $display("[TB] FAIL mid_idle: got done %b gnt %b want 0 0", r0_if.done, r0_if.gnt); end
    r0_if.req = 1'b1; r0_if.we = 1'b0; r0_if.addr = 8'd2;
    @(posedge clk); #1;
    r0_if.req = 1'b0;
    @(posedge clk); #1;
    total++; if (r0_if.done !== 1'b1 || r0_if.rdata !== 8'h02) begin bad++; $display("[TB] FAIL mid_rd2: got done %b rdata %h want 1 02", r0_if.done, r0_if.rdata); end
  endtask

  task automatic test_withdraw();
    r0_if.req = 1'b1; r0_if.we = 1'b0; r0_if.addr = 8'd7;
    #3;
    r0_if.req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      total++; if (r0_if.gnt !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0 || r0_if.done !== 1'b0) begin bad++; $display("[TB] FAIL wd_quiet%0d: got gnt %b rd %b wr %b done %b want 0", k, r0_if.gnt, mem_read, mem_write, r0_if.done); end
    end
  endtask

  // Test sequence.
  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 256; i++) mem[i] = i[7:0];
    idle_all();
    test_reset();
    test_read();
    test_write_then_read();
    test_back_to_back();
    test_out_of_range();
    test_reset_mid_access();
    test_withdraw();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Two-port round-robin arbiter and access sequencer in front of the single-port 32x8 data memory.
- Requester 0 is the CPU datapath load/store path; requester 1 is the debug/loader port used to inspect or preload data memory.
- The block serialises accesses and drives the memory's mem_read/mem_write/address/write_data pins.
- It returns registered read data with a done/err pulse, and rejects out-of-range addresses.

Parameters:
ADDR_W, 8, address width of requesters and memory
DATA_W, 8, data width
DEPTH, 32, number of valid memory words; addresses >= DEPTH are errors

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
r0_req  in  1  requester 0 access request
r0_we  in  1  requester 0 write (1) / read (0)
r0_addr  in  ADDR_W  requester 0 address
r0_wdata  in  DATA_W  requester 0 write data
r0_gnt  out  1  one-cycle pulse: r0 request accepted
r0_done  out  1  one-cycle pulse: r0 access complete
r0_err  out  1  valid with r0_done: address out of range
r0_rdata  out  DATA_W  read data, valid with r0_done
r1_req, r1_we, r1_addr, r1_wdata, r1_gnt, r1_done, r1_err, r1_rdata  same as r0 for requester 1
mem_read  out  1  to data memory read enable
mem_write  out  1  to data memory write enable
mem_address  out  ADDR_W  to data memory address
mem_write_data  out  DATA_W  to data memory write data
mem_read_data  in  DATA_W  from data memory (combinational read)

Behaviour:
- Reset (async, immediate):
  - State = IDLE; last_grant = 1, so r0 wins the first tie.
  - All outputs are 0: gnt, done, err, rdata, mem_read, mem_write, mem_address, mem_write_data.
- States: IDLE, ACCESS.
- IDLE, at a rising edge:
  - If any req is high, select a winner.
  - If only one requester is high, that requester wins.
  - If both are high, the winner is the requester != last_grant.
  - Latch we/addr/wdata/id of the winner; last_grant <= winner; state -> ACCESS.
  - winner_gnt = 1 for exactly the ACCESS cycle.
  - With no req, stay in IDLE.
- ACCESS (exactly one cycle):
  - mem_address and mem_write_data are driven from the latched registers.
  - If addr < DEPTH: mem_write = we, mem_read = !we.
  - If addr >= DEPTH: mem_read = mem_write = 0 (no memory side effect).
- ACCESS, at the next edge: state -> IDLE, and the winner's done output = 1 for one cycle.
  - Read: winner_rdata <= mem_read_data.
  - Write: winner_rdata <= 0.
  - Error: winner_err = 1, winner_rdata = 0.
- rdata holds its value until that requester's next done. done and err are 0 outside the done cycle.
- Latency: req sampled at edge E1 -> gnt high E1..E2 -> memory write commits at E2 -> done high E2..E3.
- Throughput: one access per 2 cycles. A new arbitration happens at E3, the edge ending the done cycle.
- Handshake:
  - A requester holds req/we/addr/wdata stable until it sees gnt.
  - It may change or drop them in the cycle after gnt.
  - req still high in the done cycle is a new request.
  - req dropped before gnt is a legal withdrawal; no access occurs.
- Fairness: under continuous requests from both, grants alternate r0, r1, r0, ...
- mem_address and mem_write_data hold their last values in IDLE. mem_read and mem_write are 0 in IDLE.
- Reset during ACCESS: mem_write drops immediately and the write is not committed. No done pulse is produced; state is IDLE.
- Address width rule: comparison against DEPTH is on the full ADDR_W-bit unsigned address. There is no wrap or truncation.

Test Plan:
- Reset then r0 read addr 5 (memory preloaded mem[i]=i) -> r0_gnt 1 cycle after req edge; mem_read=1, mem_address=5 during gnt; next cycle r0_done=1, r0_rdata=8'h05, r0_err=0.
- r1 write addr 3 data 8'hA5, then r0 read addr 3 -> mem_write=1 for one cycle; r1_done with r1_rdata=0; r0_rdata=8'hA5.
- r0 and r1 request the same cycle, held continuously for 6 accesses -> grant order r0,r1,r0,r1,r0,r1; each access 2 cycles; no cycle with both gnt or both done high.
- r1 write addr 8'd32 data 8'hFF -> mem_write and mem_read stay 0; r1_done=1 with r1_err=1, r1_rdata=0; subsequent read of addr 31 returns the unchanged value.
- Assert reset mid-ACCESS of r0 write addr 2 data 8'h77 -> all outputs 0 within the same cycle; no r0_done; after release, a read of addr 2 returns the reset value 8'h02.
- r0 req for one cycle, dropped before any edge samples it -> no gnt, no memory enables, state stays IDLE.
